// File: rtl/clockworks_pkg.sv
// Shared constants and elaboration helpers for the clockworks clock/reset generator.
package clockworks_pkg;

  localparam int HOLD_W      = 8;
  localparam int SYNC_STAGES = 2;

  // Divider width; SLOW=0 has no divider, but a 1-bit floor avoids zero-width declarations.
  function automatic int cnt_w(input int slow);
    return (slow < 1) ? 1 : slow;
  endfunction

  // Counter value one CLK edge before clk rises.
  function automatic logic [31:0] tick_val(input int slow);
    return (slow < 1) ? 32'd0 : (32'd1 << (slow - 1)) - 32'd1;
  endfunction

endpackage

// File: rtl/clockworks_if.sv
// Divided clock, its reset and the pre-edge strobe, as handed to downstream logic.
interface clockworks_if;
  logic clk;
  logic resetn;
  logic tick;

  modport master (output clk, resetn, tick);
  modport slave  (input  clk, resetn, tick);
endinterface

// File: rtl/clockworks_reset_sync.sv
// RESET synchroniser: asserts asynchronously, releases after SYNC_STAGES CLK edges.
module clockworks_reset_sync
  import clockworks_pkg::*;
(
  input  logic CLK,
  input  logic RESET,
  output logic rst_s
);

  logic [SYNC_STAGES-1:0] sync_q;

  always_ff @(posedge CLK or posedge RESET)
    if (RESET) sync_q <= '1;
    else       sync_q <= {sync_q[SYNC_STAGES-2:0], 1'b0};

  assign rst_s = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/clockworks.sv
// Clock divider plus reset generator: clk = CLK / 2^SLOW, resetn released on the
// RESET_HOLD-th clk rising edge after RESET is synchronously released.
module clockworks
  import clockworks_pkg::*;
#(
  parameter int SLOW       = 21,
  parameter int RESET_HOLD = 4
) (
  input  logic         CLK,
  input  logic         RESET,
  clockworks_if.master cw
);

  localparam logic [HOLD_W-1:0] HOLD = HOLD_W'(RESET_HOLD);

  logic              rst_s;
  logic              tick_int;
  logic [HOLD_W-1:0] hold_q;
  logic [HOLD_W-1:0] hold_d;
  logic              resetn_q;

  clockworks_reset_sync u_sync (
    .CLK   (CLK),
    .RESET (RESET),
    .rst_s (rst_s)
  );

  generate
    if (SLOW == 0) begin : g_pass
      assign cw.clk   = CLK;
      assign tick_int = 1'b1;
    end else begin : g_div
      localparam int          CW = cnt_w(SLOW);
      localparam logic [31:0] TV = tick_val(SLOW);

      logic [CW-1:0] cnt_q;
      logic [CW-1:0] cnt_d;
      logic          tick_q;

      assign cnt_d = cnt_q + CW'(1);

      // tick is registered against the next count so it is high exactly while cnt == TV.
      always_ff @(posedge CLK or posedge rst_s)
        if (rst_s) begin
          cnt_q  <= '0;
          tick_q <= 1'b0;
        end else begin
          cnt_q  <= cnt_d;
          tick_q <= (cnt_d == TV[CW-1:0]);
        end

      assign cw.clk   = cnt_q[CW-1];
      assign tick_int = tick_q;
    end
  endgenerate

  assign hold_d = hold_q + HOLD_W'(1);

  // Counting only on tick edges lands the resetn release on a clk rising edge.
  always_ff @(posedge CLK or posedge rst_s)
    if (rst_s) begin
      hold_q   <= '0;
      resetn_q <= 1'b0;
    end else if (tick_int && (hold_q != HOLD)) begin
      hold_q <= hold_d;
      if (hold_d == HOLD) resetn_q <= 1'b1;
    end

  assign cw.resetn = resetn_q;
  assign cw.tick   = tick_int;

endmodule

// File: tb/tb_clockworks.sv
// Directed bench: SLOW=2/RESET_HOLD=4 and SLOW=0/RESET_HOLD=1 instances on a shared CLK/RESET.
module tb_clockworks;

  logic CLK;
  logic RESET;
  int   n_chk;
  int   n_err;

  clockworks_if if2 ();
  clockworks_if if0 ();

  clockworks #(.SLOW(2), .RESET_HOLD(4)) u2 (.CLK(CLK), .RESET(RESET), .cw(if2));
  clockworks #(.SLOW(0), .RESET_HOLD(1)) u0 (.CLK(CLK), .RESET(RESET), .cw(if0));

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // Edge k counts CLK rises after RESET release. The synchroniser frees the
  // divider at k=2, so for k>=2 the SLOW=2 counter holds (k-2)%4, clk rises at
  // k=4,8,12,16 and resetn follows on the 4th rise (k=16). SLOW=0/HOLD=1
  // releases one edge after the synchroniser, k=3.
  task automatic release_seq(input string tag, input int n);
    int cnt;
    for (int k = 1; k <= n; k++) begin
      step();
      cnt = (k < 2) ? 0 : (k - 2) % 4;
      chk($sformatf("%s s2.clk k=%0d", tag, k),    32'(if2.clk),    32'(cnt >= 2));
      chk($sformatf("%s s2.tick k=%0d", tag, k),   32'(if2.tick),   32'(cnt == 1));
      chk($sformatf("%s s2.resetn k=%0d", tag, k), 32'(if2.resetn), 32'(k >= 16));
      chk($sformatf("%s s0.resetn k=%0d", tag, k), 32'(if0.resetn), 32'(k >= 3));
      chk($sformatf("%s s0.tick k=%0d", tag, k),   32'(if0.tick),   32'd1);
      chk($sformatf("%s s0.clk hi k=%0d", tag, k), 32'(if0.clk),    32'd1);
    end
  endtask

  initial begin
    n_chk = 0;
    n_err = 0;
    RESET = 1'b1;

    repeat (3) step();
    chk("rst s2.clk",    32'(if2.clk),    32'd0);
    chk("rst s2.tick",   32'(if2.tick),   32'd0);
    chk("rst s2.resetn", 32'(if2.resetn), 32'd0);
    chk("rst s0.resetn", 32'(if0.resetn), 32'd0);
    chk("rst s0.tick",   32'(if0.tick),   32'd1);
    @(negedge CLK);
    #1;
    chk("rst s0.clk lo", 32'(if0.clk),    32'd0);

    // Plain release followed by a long stretch with resetn held high.
    step();
    RESET = 1'b0;
    release_seq("rel1", 20);
    for (int k = 0; k < 8; k++) begin
      step();
      chk($sformatf("hold s2.resetn %0d", k), 32'(if2.resetn), 32'd1);
      chk($sformatf("hold s0.resetn %0d", k), 32'(if0.resetn), 32'd1);
    end

    // Abort the hold phase after two clk rises, while clk is high (k=9).
    step();
    RESET = 1'b1;
    step();
    RESET = 1'b0;
    release_seq("mid", 9);
    RESET = 1'b1;
    #1;
    chk("mid s2.clk forced",  32'(if2.clk),    32'd0);
    chk("mid s2.tick forced", 32'(if2.tick),   32'd0);
    chk("mid s2.resetn",      32'(if2.resetn), 32'd0);
    chk("mid s0.resetn",      32'(if0.resetn), 32'd0);
    repeat (2) step();
    chk("mid held s2.resetn", 32'(if2.resetn), 32'd0);
    RESET = 1'b0;
    release_seq("rel2", 20);

    // Sub-period RESET glitch while fully running.
    repeat (3) step();
    chk("pre glitch s2.resetn", 32'(if2.resetn), 32'd1);
    RESET = 1'b1;
    #2;
    RESET = 1'b0;
    chk("glitch s2.resetn", 32'(if2.resetn), 32'd0);
    chk("glitch s2.clk",    32'(if2.clk),    32'd0);
    chk("glitch s0.resetn", 32'(if0.resetn), 32'd0);
    release_seq("glt", 20);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
